// File: rtl/mem_stage_if.sv
// mem_stage_if: E/M-stage-to-data-memory bundle for mem_stage_ctrl
//  master: the controller (drives the memory request, stall/kill and status)
//  slave : the pipeline plus memory environment (drives the M-stage fields and the memory response)
interface mem_stage_if #(parameter int DATA_WIDTH = 32, parameter int CNT_W = 32);
  logic                  M_valid;
  logic                  M_mem_read;
  logic                  M_mem_write;
  logic [1:0]            M_type_control;
  logic [DATA_WIDTH-1:0] M_alu_result;
  logic [DATA_WIDTH-1:0] M_write_data;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_req;
  logic                  mem_we;
  logic [1:0]            mem_size;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] M_read_data;
  logic                  stall_pipe;
  logic                  kill_wb;
  logic                  timeout_err;
  logic                  misalign_err;
  logic [CNT_W-1:0]      stall_cycles;
  modport master (
    input  M_valid, M_mem_read, M_mem_write, M_type_control, M_alu_result, M_write_data, mem_ack, mem_rdata,
    output mem_req, mem_we, mem_size, mem_addr, mem_wdata, M_read_data, stall_pipe, kill_wb,
           timeout_err, misalign_err, stall_cycles
  );
  modport slave (
    output M_valid, M_mem_read, M_mem_write, M_type_control, M_alu_result, M_write_data, mem_ack, mem_rdata,
    input  mem_req, mem_we, mem_size, mem_addr, mem_wdata, M_read_data, stall_pipe, kill_wb,
           timeout_err, misalign_err, stall_cycles
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: sequences M-stage loads/stores against a variable-latency data memory
//  clk, rst : clock, synchronous active-high reset
//  io_bus   : mem_stage_if.master -- M-stage fields and memory response in; mem_req/we/size/addr/wdata,
//             M_read_data, stall_pipe, kill_wb, sticky timeout_err/misalign_err, saturating stall_cycles out
module mem_stage_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 32
) (
  input logic         clk,
  input logic         rst,
  mem_stage_if.master io_bus
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;
  logic [0:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_terr;
  logic             r_merr;
  logic [CNT_W-1:0] r_stall;
  logic             w_access;
  logic             w_misal;
  logic             w_wait;
  logic             w_go;
  logic             w_tmo;
  logic             w_done;
  logic             w_stall;
  always_comb begin
    w_access = io_bus.M_valid & (io_bus.M_mem_read | io_bus.M_mem_write);
    w_misal  = io_bus.M_type_control == 2'b01 ? io_bus.M_alu_result[0] :
               io_bus.M_type_control == 2'b10 ? 1'b0 : |io_bus.M_alu_result[1:0];
    w_wait   = r_state == S_WAIT;
    w_go     = w_access & ~w_misal;
    // ack wins over a timeout landing in the same cycle
    w_tmo    = w_wait & ~io_bus.mem_ack & (r_cnt == CW'(TIMEOUT_CYCLES - 1));
    w_done   = io_bus.mem_ack | w_tmo;
    w_stall  = w_wait ? ~w_done : w_go & ~io_bus.mem_ack;
  end
  assign io_bus.mem_req      = w_wait | w_go;
  assign io_bus.mem_we       = io_bus.M_mem_write;
  assign io_bus.mem_size     = io_bus.M_type_control;
  assign io_bus.mem_addr     = io_bus.M_alu_result;
  assign io_bus.mem_wdata    = io_bus.M_write_data;
  assign io_bus.M_read_data  = io_bus.mem_rdata;
  assign io_bus.stall_pipe   = w_stall;
  assign io_bus.kill_wb      = w_wait ? w_tmo : w_access & w_misal;
  assign io_bus.timeout_err  = r_terr;
  assign io_bus.misalign_err = r_merr;
  assign io_bus.stall_cycles = r_stall;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_terr  <= 1'b0;
      r_merr  <= 1'b0;
      r_stall <= '0;
    end else begin
      if (w_wait) begin
        r_state <= w_done ? S_IDLE : S_WAIT;
        r_cnt   <= w_done ? '0 : r_cnt + 1'b1;
      end else if (w_stall) begin
        r_state <= S_WAIT;
        r_cnt   <= CW'(1);
      end
      if (w_tmo) r_terr <= 1'b1;
      if (~w_wait & w_access & w_misal) r_merr <= 1'b1;
      if (w_stall & ~&r_stall) r_stall <= r_stall + 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: randomized scoreboard bench for mem_stage_ctrl against a per-instruction reference model
module tb_mem_stage_ctrl;
  localparam int DW = 32;
  localparam int T  = 64;
  localparam int NEVER = 1000;
  typedef struct {
    int          stall;
    int          req;
    int          kill;
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        terr;
    logic        merr;
    int          tot;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  logic mon_en = 1'b0;
  logic m_terr = 1'b0;
  logic m_merr = 1'b0;
  int   m_tot = 0;
  exp_t q[$];
  mem_stage_if #(.DATA_WIDTH(DW), .CNT_W(32)) io_bus ();
  mem_stage_ctrl #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(T), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .io_bus(io_bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive(input logic v, input logic rd, input logic wr, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat);
    io_bus.M_valid        = v;
    io_bus.M_mem_read     = rd;
    io_bus.M_mem_write    = wr;
    io_bus.M_type_control = sz;
    io_bus.M_alu_result   = a;
    io_bus.M_write_data   = wd;
    io_bus.mem_rdata      = rdat;
    io_bus.mem_ack        = 1'b0;
  endtask
  task automatic run(input logic v, input logic rd, input logic wr, input logic [1:0] sz,
                     input logic [31:0] a, input int lat);
    exp_t e;
    logic acc, mis, done;
    int   k;
    logic [31:0] rdat;
    rdat = $urandom;
    acc = v & (rd | wr);
    mis = (sz == 2'd1) ? (a % 2 != 0) : (sz == 2'd2) ? 1'b0 : (a % 4 != 0);
    e.we = wr; e.size = sz; e.addr = a; e.rdata = rdat;
    e.terr = m_terr; e.merr = m_merr;
    if (!acc) begin
      e.stall = 0; e.req = 0; e.kill = 0;
    end else if (mis) begin
      e.stall = 0; e.req = 0; e.kill = 1; m_merr = 1'b1;
    end else if (lat <= T - 1) begin
      e.stall = lat; e.req = lat + 1; e.kill = 0;
    end else begin
      e.stall = T - 1; e.req = T; e.kill = 1; m_terr = 1'b1;
    end
    m_tot += e.stall;
    e.tot = m_tot;
    q.push_back(e);
    drive(v, rd, wr, sz, a, $urandom, rdat);
    mon_en = 1'b1;
    k = 0;
    done = 1'b0;
    while (!done) begin
      io_bus.mem_ack = acc & !mis & (k == lat);
      @(negedge clk);
      done = !io_bus.stall_pipe;
      @(posedge clk);
      #1;
      k++;
      if (!done && k > T + 8) begin
        n_chk++; n_fail++;
        $display("FAIL stall_bound: stall_pipe still high after %0d cycles", k);
        $fatal(1, "stall never released");
      end
    end
  endtask
  int st_n = 0, rq_n = 0, kl_n = 0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (io_bus.stall_pipe) st_n++;
      if (io_bus.mem_req) rq_n++;
      if (io_bus.kill_wb) kl_n++;
      if (!io_bus.stall_pipe) begin
        if (q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL sb_empty: instruction retired with no expectation");
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("stall_n", 64'(st_n), 64'(e.stall));
          chk("req_n", 64'(rq_n), 64'(e.req));
          chk("kill_n", 64'(kl_n), 64'(e.kill));
          chk("mem_we", 64'(io_bus.mem_we), 64'(e.we));
          chk("mem_size", 64'(io_bus.mem_size), 64'(e.size));
          chk("mem_addr", 64'(io_bus.mem_addr), 64'(e.addr));
          chk("rdata", 64'(io_bus.M_read_data), 64'(e.rdata));
          chk("timeout_err", 64'(io_bus.timeout_err), 64'(e.terr));
          chk("misalign_err", 64'(io_bus.misalign_err), 64'(e.merr));
          chk("stall_cycles", 64'(io_bus.stall_cycles), 64'(e.tot));
        end
        st_n = 0; rq_n = 0; kl_n = 0;
      end
    end
  end
  initial begin
    int r, lat;
    logic [31:0] a;
    drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_req", 64'(io_bus.mem_req), 64'd0);
    chk("rst_stall", 64'(io_bus.stall_pipe), 64'd0);
    chk("rst_kill", 64'(io_bus.kill_wb), 64'd0);
    chk("rst_terr", 64'(io_bus.timeout_err), 64'd0);
    chk("rst_merr", 64'(io_bus.misalign_err), 64'd0);
    chk("rst_cnt", 64'(io_bus.stall_cycles), 64'd0);
    @(posedge clk);
    #1;
    run(1, 1, 0, 2'd0, 32'h100, 0);
    run(1, 0, 1, 2'd0, 32'h200, 3);
    run(1, 1, 0, 2'd1, 32'h101, 0);
    run(0, 1, 0, 2'd0, 32'h300, 0);
    run(1, 1, 0, 2'd0, 32'h400, T - 1);
    run(1, 1, 1, 2'd3, 32'h404, 2);
    run(1, 1, 0, 2'd2, 32'h403, 1);
    run(1, 1, 0, 2'd0, 32'h500, NEVER);
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      lat = r < 4 ? r : r == 4 ? T - 2 : r == 5 ? T - 1 : r == 6 ? NEVER : $urandom_range(0, 5);
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      run($urandom_range(0, 7) != 0, 1'($urandom), 1'($urandom), 2'($urandom), a, lat);
    end
    mon_en = 1'b0;
    chk("sb_drained", 64'(q.size()), 64'd0);
    drive(1, 1, 0, 2'd0, 32'h600, 32'h0, 32'h0);
    @(negedge clk);
    chk("rt_stall0", 64'(io_bus.stall_pipe), 64'd1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    drive(0, 1, 0, 2'd0, 32'h600, 32'h0, 32'h0);
    @(negedge clk);
    chk("rt_req", 64'(io_bus.mem_req), 64'd0);
    chk("rt_stall", 64'(io_bus.stall_pipe), 64'd0);
    chk("rt_terr", 64'(io_bus.timeout_err), 64'd0);
    chk("rt_merr", 64'(io_bus.misalign_err), 64'd0);
    chk("rt_cnt", 64'(io_bus.stall_cycles), 64'd0);
    drive(1, 1, 0, 2'd0, 32'h602, 32'h0, 32'h0);
    @(negedge clk);
    chk("rt_idle_req", 64'(io_bus.mem_req), 64'd0);
    chk("rt_idle_kill", 64'(io_bus.kill_wb), 64'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
